// File: rtl/wired_bus_resolver.sv
// Registered N-driver bus resolver: wired-OR, wired-AND or tri-state, with contention/floating flags.
// Optional sticky contention error (clr_err / err_sticky) enabled by macro WIRED_BUS_STICKY_ERR_EN.
module wired_bus_resolver #(
   parameter int N_DRV = 4,
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [1:0]             mode,
   input  logic [N_DRV-1:0]       drv_en,
   input  logic [N_DRV*WIDTH-1:0] drv_data,
   input  logic                   clr_cnt,
`ifdef WIRED_BUS_STICKY_ERR_EN
   input  logic                   clr_err,
   output logic                   err_sticky,
`endif
   output logic                   out_valid,
   output logic [WIDTH-1:0]       bus_out,
   output logic                   contention,
   output logic                   floating,
   output logic [CNT_W-1:0]       cont_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] or_s;
   logic [WIDTH-1:0] and_s;
   logic [WIDTH-1:0] bus_s;
   logic             seen_s;
   logic             multi_s;
   logic             cont_s;
   logic             float_s;
   logic             cnt_sat_s;

   // reduce enabled drivers; multi_s marks a second enabled driver
   always_comb begin
      or_s    = '0;
      and_s   = '1;
      seen_s  = 1'b0;
      multi_s = 1'b0;
      for (int i = 0; i < N_DRV; i++) begin
         or_s    = or_s  | (drv_data[i*WIDTH +: WIDTH] & {WIDTH{drv_en[i]}});
         and_s   = and_s & (drv_data[i*WIDTH +: WIDTH] | {WIDTH{~drv_en[i]}});
         multi_s = multi_s | (seen_s & drv_en[i]);
         seen_s  = seen_s | drv_en[i];
      end
   end

   // mode select; tri-state resolves to the OR of its enabled drivers in every case
   always_comb begin
      bus_s   = or_s;
      cont_s  = 1'b0;
      float_s = ~seen_s;
      case (mode)
         2'b01: begin
            bus_s  = and_s;
            cont_s = 1'b0;
         end
         2'b10: begin
            bus_s  = or_s;
            cont_s = multi_s;
         end
         default: begin
            bus_s  = or_s;
            cont_s = 1'b0;
         end
      endcase
   end

   assign cnt_sat_s = &cont_cnt;

   // output registers: results load only on accepted samples, valid follows in_valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         bus_out    <= '0;
         contention <= 1'b0;
         floating   <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            bus_out    <= bus_s;
            contention <= cont_s;
            floating   <= float_s;
         end
      end
   end

   // saturating contention counter; clear beats increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cont_cnt <= '0;
      end else if (clr_cnt) begin
         cont_cnt <= '0;
      end else if (in_valid && cont_s && !cnt_sat_s) begin
         cont_cnt <= cont_cnt + CNT_ONE;
      end
   end

`ifdef WIRED_BUS_STICKY_ERR_EN
   // sticky error: a new contention sample wins over clr_err
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sticky <= 1'b0;
      end else if (in_valid && cont_s) begin
         err_sticky <= 1'b1;
      end else if (clr_err) begin
         err_sticky <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_wired_bus_resolver.sv
// Scoreboard bench for wired_bus_resolver (N_DRV=4, WIDTH=8, CNT_W=2).
module tb_wired_bus_resolver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [3:0]  drv_en = 4'b0000;
   logic [31:0] drv_data = 32'h0;
   logic        clr_cnt = 1'b0;
   logic        clr_err = 1'b0;
   logic        out_valid;
   logic [7:0]  bus_out;
   logic        contention;
   logic        floating;
   logic [1:0]  cont_cnt;
`ifdef WIRED_BUS_STICKY_ERR_EN
   logic        err_sticky;
   localparam bit HAS_ERR = 1'b1;
`else
   logic        err_sticky;
   assign err_sticky = 1'b0;
   localparam bit HAS_ERR = 1'b0;
`endif

   wired_bus_resolver #(.N_DRV(4), .WIDTH(8), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
      .drv_en(drv_en), .drv_data(drv_data), .clr_cnt(clr_cnt),
`ifdef WIRED_BUS_STICKY_ERR_EN
      .clr_err(clr_err), .err_sticky(err_sticky),
`endif
      .out_valid(out_valid), .bus_out(bus_out), .contention(contention),
      .floating(floating), .cont_cnt(cont_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       v;
      logic [7:0] bus;
      logic       cont;
      logic       flt;
      logic [1:0] cnt;
      logic       err;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   logic [7:0] m_bus = 8'h00;
   logic       m_cont = 1'b0;
   logic       m_flt = 1'b0;
   logic [1:0] m_cnt = 2'd0;
   logic       m_err = 1'b0;

   // drive one sample at negedge, push the model's expectation, wait until just after the edge
   task automatic step(input logic v, input logic [1:0] md, input logic [3:0] en,
                       input logic [31:0] d, input logic cc, input logic ce);
      logic [7:0] o;
      logic [7:0] a;
      int         k;
      logic       c_now;
      @(negedge clk);
      in_valid = v; mode = md; drv_en = en; drv_data = d; clr_cnt = cc; clr_err = ce;
      o = 8'h00; a = 8'hFF; k = 0;
      for (int i = 0; i < 4; i++) begin
         if (en[i]) begin
            o = o | d[i*8 +: 8];
            a = a & d[i*8 +: 8];
            k++;
         end
      end
      c_now = v && (md == 2'b10) && (k > 1);
      if (v) begin
         m_bus  = (md == 2'b01) ? a : o;
         m_cont = c_now;
         m_flt  = (k == 0);
      end
      if (cc) m_cnt = 2'd0;
      else if (c_now && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
      if (c_now) m_err = 1'b1;
      else if (ce) m_err = 1'b0;
      sb.push_back('{v, m_bus, m_cont, m_flt, m_cnt, m_err});
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_bus = 8'h00; m_cont = 1'b0; m_flt = 1'b0; m_cnt = 2'd0; m_err = 1'b0;
      sb.delete();
   endtask

   task automatic test_reset();
      #1;
      total_cnt++;
      if ({out_valid, bus_out, contention, floating, cont_cnt, err_sticky} !== 14'h0) begin
         $display("FAIL reset_initial: got %h want 0",
                  {out_valid, bus_out, contention, floating, cont_cnt, err_sticky});
      end else pass_cnt++;
      @(negedge clk); rst_n = 1'b1;
      // push some state in, then assert reset between edges
      step(1'b1, 2'b10, 4'b0110, 32'h00A50100, 1'b0, 1'b0);
      e = sb.pop_front();
      total_cnt++;
      if ({out_valid, bus_out, contention, cont_cnt} !== {e.v, e.bus, e.cont, e.cnt}) begin
         $display("FAIL reset_prefill: got %h want %h", {out_valid, bus_out, contention, cont_cnt},
                  {e.v, e.bus, e.cont, e.cnt});
      end else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({out_valid, bus_out, contention, floating, cont_cnt, err_sticky} !== 14'h0) begin
         $display("FAIL reset_async: got %h want 0",
                  {out_valid, bus_out, contention, floating, cont_cnt, err_sticky});
      end else pass_cnt++;
      model_reset();
      in_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_wired_or();
      logic [3:0]  en_t [4] = '{4'b0101, 4'b0000, 4'b1111, 4'b0010};
      logic [1:0]  md_t [4] = '{2'b00, 2'b00, 2'b11, 2'b11};
      logic [31:0] d_t  [4] = '{32'hFFF0FF0F, 32'hFFF0FF0F, 32'h01020408, 32'h000055AA};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, md_t[i], en_t[i], d_t[i], 1'b0, 1'b0);
         e = sb.pop_front();
         total_cnt++;
         if ({out_valid, bus_out, contention, floating} !== {e.v, e.bus, e.cont, e.flt}) begin
            $display("FAIL wired_or[%0d]: got v=%b bus=%h c=%b f=%b want v=%b bus=%h c=%b f=%b", i,
                     out_valid, bus_out, contention, floating, e.v, e.bus, e.cont, e.flt);
         end else pass_cnt++;
      end
   endtask

   task automatic test_wired_and();
      logic [3:0]  en_t [3] = '{4'b0011, 4'b0000, 4'b1001};
      logic [31:0] d_t  [3] = '{32'h00000F3C, 32'h00000F3C, 32'hF0FFFF3F};
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 2'b01, en_t[i], d_t[i], 1'b0, 1'b0);
         e = sb.pop_front();
         total_cnt++;
         if ({out_valid, bus_out, contention, floating} !== {e.v, e.bus, e.cont, e.flt}) begin
            $display("FAIL wired_and[%0d]: got bus=%h c=%b f=%b want bus=%h c=%b f=%b", i,
                     bus_out, contention, floating, e.bus, e.cont, e.flt);
         end else pass_cnt++;
      end
   endtask

   task automatic test_tri();
      logic [3:0]  en_t [3] = '{4'b0100, 4'b0110, 4'b0000};
      logic [31:0] d_t  [3] = '{32'h00A50000, 32'h00A50100, 32'hFFFFFFFF};
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 2'b10, en_t[i], d_t[i], 1'b0, 1'b0);
         e = sb.pop_front();
         total_cnt++;
         if ({out_valid, bus_out, contention, floating, cont_cnt} !== {e.v, e.bus, e.cont, e.flt, e.cnt}) begin
            $display("FAIL tri[%0d]: got bus=%h c=%b f=%b cnt=%0d want bus=%h c=%b f=%b cnt=%0d", i,
                     bus_out, contention, floating, cont_cnt, e.bus, e.cont, e.flt, e.cnt);
         end else pass_cnt++;
      end
   endtask

   task automatic test_counter();
      for (int i = 0; i < 6; i++) begin
         // last sample is contention with clr_cnt at the same time
         step(1'b1, 2'b10, 4'b1100, 32'h12340000, (i == 5), 1'b0);
         e = sb.pop_front();
         total_cnt++;
         if ({cont_cnt, contention} !== {e.cnt, e.cont}) begin
            $display("FAIL counter[%0d]: got cnt=%0d c=%b want cnt=%0d c=%b", i,
                     cont_cnt, contention, e.cnt, e.cont);
         end else pass_cnt++;
      end
   endtask

   task automatic test_sticky();
      for (int i = 0; i < 13; i++) begin
         // 0: contention, 1-10 clean, 11 clr_err, 12 contention with clr_err
         step(1'b1, 2'b10, (i == 0 || i == 12) ? 4'b0011 : 4'b0001,
              32'h00000201, 1'b0, (i >= 11));
         e = sb.pop_front();
         total_cnt++;
         if ({contention, (HAS_ERR ? err_sticky : 1'b0)} !== {e.cont, (HAS_ERR ? e.err : 1'b0)}) begin
            $display("FAIL sticky[%0d]: got c=%b err=%b want c=%b err=%b", i,
                     contention, err_sticky, e.cont, e.err);
         end else pass_cnt++;
      end
   endtask

   task automatic test_gap();
      step(1'b1, 2'b00, 4'b1010, 32'h5A003C00, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         e = sb.pop_front();
         total_cnt++;
         if ({out_valid, bus_out, contention, floating} !== {e.v, e.bus, e.cont, e.flt}) begin
            $display("FAIL gap[%0d]: got v=%b bus=%h want v=%b bus=%h", i,
                     out_valid, bus_out, e.v, e.bus);
         end else pass_cnt++;
         if (i < 3) step(1'b0, 2'($urandom_range(3)), 4'($urandom), $urandom, 1'b0, 1'b0);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         step(($urandom_range(3) != 0), 2'($urandom_range(3)), 4'($urandom), $urandom,
              ($urandom_range(7) == 0), ($urandom_range(7) == 0));
         e = sb.pop_front();
         total_cnt++;
         if ({out_valid, bus_out, contention, floating, cont_cnt, (HAS_ERR ? err_sticky : 1'b0)} !==
             {e.v, e.bus, e.cont, e.flt, e.cnt, (HAS_ERR ? e.err : 1'b0)}) begin
            $display("FAIL random[%0d]: got v=%b bus=%h c=%b f=%b cnt=%0d err=%b want v=%b bus=%h c=%b f=%b cnt=%0d err=%b",
                     i, out_valid, bus_out, contention, floating, cont_cnt, err_sticky,
                     e.v, e.bus, e.cont, e.flt, e.cnt, e.err);
         end else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_wired_or();
      test_wired_and();
      test_tri();
      test_counter();
      test_sticky();
      test_gap();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
